// File: rtl/game_i2c_pkg.sv
// Shared types for the game-side I2C event path:
// command codes, event classes, scheduler states and the frame bundle.
package game_i2c_pkg;

  localparam logic [7:0] CMD_UP_P1   = 8'h01;
  localparam logic [7:0] CMD_DOWN_P1 = 8'h02;
  localparam logic [7:0] CMD_UP_P2   = 8'h03;
  localparam logic [7:0] CMD_DOWN_P2 = 8'h04;
  localparam logic [7:0] CMD_SHOW    = 8'h10;
  localparam logic [7:0] CMD_FINAL   = 8'h20;
  localparam logic [7:0] CMD_RESTART = 8'h7F;

  // Event classes, index 0 is the highest priority
  localparam int EV_RESTART = 0;
  localparam int EV_FINAL   = 1;
  localparam int EV_SHOW    = 2;
  localparam int EV_UP_P1   = 3;
  localparam int EV_DOWN_P1 = 4;
  localparam int EV_UP_P2   = 5;
  localparam int EV_DOWN_P2 = 6;
  localparam int NUM_EV     = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    REISSUE
  } state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
  } frame_t;

  function automatic frame_t mk_frame(
    input logic [7:0] cmd,
    input logic [7:0] data
  );
    frame_t f;
    f.cmd  = cmd;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/i2c_evt_fifo.sv
// Synchronous frame FIFO with flush; flush+push leaves exactly the pushed frame.
// Ports: clk, rst_n, push/push_frame, pop, flush, head, full, empty, level.
module i2c_evt_fifo
  import game_i2c_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  frame_t                   push_frame,
  input  logic                     pop,
  input  logic                     flush,
  output frame_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  frame_t          mem_q [DEPTH];
  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;
  logic            we;
  logic [AW-1:0]   waddr;

  assign level = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (level == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    we    = 1'b0;
    waddr = wr_q[AW-1:0];
    if (flush) begin
      rd_d  = '0;
      wr_d  = push ? (AW+1)'(1) : '0;
      we    = push;
      waddr = '0;
    end else begin
      if (push && !full) begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (we) begin
        mem_q[waddr] <= push_frame;
      end
    end
  end

endmodule

// File: rtl/i2c_event_scheduler.sv
// Turns game-event pulses into queued 2-byte I2C frames with retry/drop.
// Ports: event pulses+payloads in, oReq/oCmd/oData/iAck/iDone/iNack to master, status out.
module i2c_event_scheduler
  import game_i2c_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 1000,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          iClk,
  input  logic                          iRst_n,
  input  logic                          iShow,
  input  logic                          iFinal,
  input  logic                          iRestart,
  input  logic [1:0]                    iWin,
  input  logic [1:0]                    iResult,
  input  logic                          iUp_P1,
  input  logic                          iDown_P1,
  input  logic                          iUp_P2,
  input  logic                          iDown_P2,
  output logic                          oReq,
  output logic [7:0]                    oCmd,
  output logic [7:0]                    oData,
  input  logic                          iAck,
  input  logic                          iDone,
  input  logic                          iNack,
  output logic                          oDrop,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oIdle
);

  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);
  localparam int RW0 = $clog2(MAX_RETRY + 1);
  localparam int RW  = (RW0 < 1) ? 1 : RW0;

  // ---------------- pending stage ----------------
  logic [NUM_EV-1:0] pend_q, pend_d;
  logic [NUM_EV-1:0] pulse, grant;
  logic [1:0]        win_q, win_d;
  logic [1:0]        res_q, res_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        sel;
  logic              push, flush, pop;
  frame_t            push_frame, head;
  logic              full, empty;
  logic [LW-1:0]     level;

  assign pulse = {iDown_P2, iUp_P2, iDown_P1,
                  iUp_P1, iShow, iFinal, iRestart};

  always_comb begin
    sel = 3'd0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end

  // A pending RESTART always goes: its flush makes room for itself
  assign push  = |pend_q & (pend_q[EV_RESTART] | ~full);
  assign flush = pend_q[EV_RESTART];

  always_comb begin
    grant = '0;
    if (push) grant[sel] = 1'b1;
  end

  always_comb begin
    push_frame = mk_frame(CMD_RESTART, 8'h00);
    unique case (sel)
      3'(EV_FINAL):   push_frame = mk_frame(CMD_FINAL, {6'b0, res_q});
      3'(EV_SHOW):    push_frame = mk_frame(CMD_SHOW, {6'b0, win_q});
      3'(EV_UP_P1):   push_frame = mk_frame(CMD_UP_P1, 8'h00);
      3'(EV_DOWN_P1): push_frame = mk_frame(CMD_DOWN_P1, 8'h00);
      3'(EV_UP_P2):   push_frame = mk_frame(CMD_UP_P2, 8'h00);
      3'(EV_DOWN_P2): push_frame = mk_frame(CMD_DOWN_P2, 8'h00);
      default:        push_frame = mk_frame(CMD_RESTART, 8'h00);
    endcase
  end

  always_comb begin
    pend_d = (pend_q & ~grant) | (pulse & ~pend_q);
    ovf_d  = ovf_q | |(pulse & pend_q);
    win_d  = (iShow & ~pend_q[EV_SHOW]) ? iWin : win_q;
    res_d  = (iFinal & ~pend_q[EV_FINAL]) ? iResult : res_q;
    if (iRestart) begin
      // restart discards everything else arriving or waiting
      pend_d = '0;
      pend_d[EV_RESTART] = 1'b1;
      ovf_d  = 1'b0;
      win_d  = win_q;
      res_d  = res_q;
    end
  end

  i2c_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (iClk),
    .rst_n      (iRst_n),
    .push       (push),
    .push_frame (push_frame),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  // ---------------- issue FSM ----------------
  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic          drop_q, drop_d;
  frame_t        fly_q, fly_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  // presented head still in the FIFO (a flush during ISSUE removes it)
  logic          live_q, live_d;
  logic          fail;

  assign fail = (iDone & iNack) | (tmo_q == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    fly_d   = fly_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    live_d  = live_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          cmd_d   = head.cmd;
          data_d  = head.data;
          live_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (flush) live_d = 1'b0;
        if (iAck) begin
          pop     = live_q;
          fly_d   = mk_frame(cmd_q, data_q);
          retry_d = '0;
          tmo_d   = '0;
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (iDone && !iNack) begin
          state_d = IDLE;
        end else if (fail) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = REISSUE;
          req_d   = 1'b1;
          cmd_d   = fly_q.cmd;
          data_d  = fly_q.data;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      REISSUE: begin
        if (iAck) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pend_q  <= '0;
      win_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      fly_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      win_q   <= win_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      fly_q   <= fly_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      live_q  <= live_d;
    end
  end

  assign oReq      = req_q;
  assign oCmd      = cmd_q;
  assign oData     = data_q;
  assign oDrop     = drop_q;
  assign oOverflow = ovf_q;
  assign oLevel    = level;
  assign oIdle     = (state_q == IDLE) & empty & ~|pend_q;

endmodule

// File: tb/tb_i2c_event_scheduler.sv
// Scoreboard bench for i2c_event_scheduler: expected frames queued at stimulus,
// compared when oReq presents them; a bench-side master drives ack/done/nack.
module tb_i2c_event_scheduler;

  localparam int FD = 8;
  localparam int MR = 2;
  localparam int GC = 10;
  localparam int TC = 60;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iShow = 0, iFinal = 0, iRestart = 0;
  logic [1:0] iWin = 0, iResult = 0;
  logic       iUp_P1 = 0, iDown_P1 = 0;
  logic       iUp_P2 = 0, iDown_P2 = 0;
  logic       iAck = 0, iDone = 0, iNack = 0;
  logic       oReq, oDrop, oOverflow, oIdle;
  logic [7:0] oCmd, oData;
  logic [3:0] oLevel;

  i2c_event_scheduler #(
    .FIFO_DEPTH  (FD),
    .MAX_RETRY   (MR),
    .GAP_CYC     (GC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iShow     (iShow),
    .iFinal    (iFinal),
    .iRestart  (iRestart),
    .iWin      (iWin),
    .iResult   (iResult),
    .iUp_P1    (iUp_P1),
    .iDown_P1  (iDown_P1),
    .iUp_P2    (iUp_P2),
    .iDown_P2  (iDown_P2),
    .oReq      (oReq),
    .oCmd      (oCmd),
    .oData     (oData),
    .iAck      (iAck),
    .iDone     (iDone),
    .iNack     (iNack),
    .oDrop     (oDrop),
    .oOverflow (oOverflow),
    .oLevel    (oLevel),
    .oIdle     (oIdle)
  );

  always #5 iClk = ~iClk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          drop_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_f;

  always @(negedge iClk) if (oDrop === 1'b1) drop_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (oReq !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (oReq !== 1'b1) check("req_wait", 32'(oReq), 32'd1);
  endtask

  task automatic do_ack(input string tag);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    check({tag, "_reqdrop"}, 32'(oReq), 32'd0);
  endtask

  task automatic take(input string tag);
    int n;
    wait_req(n);
    last_f = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    check(tag, 32'({oCmd, oData}), 32'(last_f));
    do_ack(tag);
  endtask

  task automatic done(input logic nack);
    iDone = 1'b1;
    iNack = nack;
    tick();
    iDone = 1'b0;
    iNack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    // ---- reset ----
    repeat (3) tick();
    check("rst_req", 32'(oReq), 32'd0);
    check("rst_cmd", 32'({oCmd, oData}), 32'd0);
    check("rst_flags", 32'({oDrop, oOverflow}), 32'd0);
    check("rst_level", 32'(oLevel), 32'd0);
    check("rst_idle", 32'(oIdle), 32'd1);
    iRst_n = 1'b1;
    repeat (2) tick();

    // ---- single event latency ----
    iUp_P1 = 1'b1;
    exp_q.push_back(16'h0100);
    tick();
    iUp_P1 = 1'b0;
    check("lat_c1", 32'(oReq), 32'd0);
    tick();
    check("lat_c2", 32'(oReq), 32'd0);
    check("lat_lvl", 32'(oLevel), 32'd1);
    tick();
    check("lat_c3", 32'(oReq), 32'd1);
    take("lat_frame");
    done(1'b0);
    check("lat_idle", 32'(oIdle), 32'd1);

    // ---- same-cycle priority ----
    iShow = 1; iWin = 2'd2; iUp_P2 = 1;
    iFinal = 1; iResult = 2'd1;
    exp_q.push_back(16'h2001);
    exp_q.push_back(16'h1002);
    exp_q.push_back(16'h0300);
    tick();
    iShow = 0; iUp_P2 = 0; iFinal = 0;
    iWin = 0; iResult = 0;
    for (int k = 0; k < 3; k++) begin
      take("prio_frame");
      done(1'b0);
    end

    // ---- nack retries then drop ----
    d0 = drop_cnt;
    iUp_P1 = 1; iDown_P2 = 1;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0400);
    tick();
    iUp_P1 = 0; iDown_P2 = 0;
    take("rt_first");
    for (int k = 0; k < MR; k++) begin
      iDone = 1; iNack = 1;
      n = 0;
      do begin
        tick();
        iDone = 0; iNack = 0;
        n++;
      end while (oReq !== 1'b1 && n < 500);
      check("rt_gap", 32'(n), 32'(GC + 1));
      check("rt_frame", 32'({oCmd, oData}), 32'(last_f));
      do_ack("rt_re");
    end
    iDone = 1; iNack = 1;
    tick();
    iDone = 0; iNack = 0;
    check("rt_drop", 32'(oDrop), 32'd1);
    tick();
    check("rt_drop_pulse", 32'(oDrop), 32'd0);
    take("rt_next");
    done(1'b0);
    check("rt_dropcnt", 32'(drop_cnt - d0), 32'd1);

    // ---- timeout then successful retry ----
    d0 = drop_cnt;
    iUp_P2 = 1;
    exp_q.push_back(16'h0300);
    tick();
    iUp_P2 = 0;
    take("to_first");
    n = 1;
    while (oReq !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    check("to_window",
          32'(n >= TC + GC && n <= TC + GC + 3), 32'd1);
    check("to_frame", 32'({oCmd, oData}), 32'(last_f));
    do_ack("to_re");
    done(1'b0);
    tick();
    check("to_nodrop", 32'(drop_cnt - d0), 32'd0);

    // ---- overflow on a still-pending class ----
    iDown_P1 = 1;
    exp_q.push_back(16'h0200);
    tick();
    tick();
    iDown_P1 = 0;
    check("ov_flag", 32'(oOverflow), 32'd1);
    take("ov_frame");
    done(1'b0);
    repeat (5) tick();
    check("ov_single", 32'({oReq, oLevel}), 32'd0);
    check("ov_sticky", 32'(oOverflow), 32'd1);

    // ---- fill while stalled, then restart ----
    iUp_P1 = 1;
    exp_q.push_back(16'h0100);
    tick();
    iUp_P1 = 0;
    take("rs_fly");
    for (int k = 0; k < FD; k++) begin
      iUp_P1 = 1;
      tick();
      iUp_P1 = 0;
      tick();
      exp_q.push_back(16'h0100);
    end
    check("rs_full", 32'(oLevel), 32'(FD));
    iUp_P2 = 1;
    tick();
    iUp_P2 = 0;
    tick();
    check("rs_backpr", 32'({oLevel, oIdle}), 32'({4'(FD), 1'b0}));
    iRestart = 1;
    tick();
    iRestart = 0;
    check("rs_ovclr", 32'(oOverflow), 32'd0);
    tick();
    check("rs_level", 32'(oLevel), 32'd1);
    exp_q.delete();
    exp_q.push_back(16'h7F00);
    check("rs_inflight", 32'(oReq), 32'd0);
    done(1'b0);
    take("rs_frame");
    done(1'b0);
    repeat (4) tick();
    check("rs_idle", 32'({oIdle, oLevel}), 32'({1'b1, 4'd0}));

    // ---- async reset mid-WAIT ----
    iShow = 1; iWin = 2'd3;
    exp_q.push_back(16'h1003);
    tick();
    iShow = 0; iWin = 0;
    take("ar_frame");
    repeat (3) tick();
    iRst_n = 1'b0;
    #1;
    check("ar_req", 32'(oReq), 32'd0);
    check("ar_cmd", 32'({oCmd, oData}), 32'd0);
    check("ar_stat",
          32'({oDrop, oOverflow, oLevel, oIdle}), 32'd1);
    tick();
    iRst_n = 1'b1;
    repeat (4) tick();
    check("ar_quiet", 32'({oReq, oIdle}), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_event_scheduler.md
# i2c_event_scheduler

Queues one-cycle game-event pulses from the game logic and serialises them as 2-byte command frames (command, data) onto the single I2C master of the game-side I2C path. Same-cycle events are resolved by fixed priority, buffered in a small FIFO, and issued over a req/ack/done handshake. NACKs and timeouts are retried a bounded number of times. A restart flushes stale traffic. The block sits between Game_Logic_Top and the byte-level I2C master, in the iClk domain.

## Interface
- FIFO_DEPTH, 8: frame FIFO entries (power of two, ≥4)
- MAX_RETRY, 2: re-issues after a failed transfer before the frame is dropped
- GAP_CYC, 1000: idle cycles between a failure and its retry
- TIMEOUT_CYC, 100000: maximum cycles from iAck to iDone
- iClk  in  1  system clock
- iRst_n  in  1  asynchronous, active-low reset
- iShow, iFinal, iRestart  in  1 each  event pulses
- iWin, iResult  in  2 each  payloads, sampled with iShow / iFinal
- iUp_P1, iDown_P1, iUp_P2, iDown_P2  in  1 each  event pulses
- oReq  out  1  frame request to the I2C master
- oCmd, oData  out  8 each  frame bytes; stable while oReq=1
- iAck  in  1  pulse: master accepted the frame
- iDone  in  1  pulse: transfer finished
- iNack  in  1  qualifies iDone: transfer failed
- oDrop  out  1  pulse: frame abandoned after retries
- oOverflow  out  1  sticky: an event was lost; cleared by reset or iRestart
- oLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- oIdle  out  1  FSM in IDLE, FIFO empty, no pending events

## Operation
- Command codes:
  - UP_P1=0x01, DOWN_P1=0x02, UP_P2=0x03, DOWN_P2=0x04: data 0x00.
  - SHOW=0x10: data {6'b0,iWin}.
  - FINAL=0x20: data {6'b0,iResult}.
  - RESTART=0x7F: data 0x00.
- Input stage: one pending flag plus latched payload per event class.
  - A pulse on a class that is already pending is dropped and sets oOverflow.
- Push stage: at most one push per cycle, taking the highest-priority pending class.
  - Priority: RESTART > FINAL > SHOW > UP_P1 > DOWN_P1 > UP_P2 > DOWN_P2.
  - FIFO full: pending flags hold (backpressure). No drop occurs here.
- iRestart:
  - Clears all other pending flags, all FIFO contents, and oOverflow.
  - Pushes RESTART as the next FIFO entry.
  - An in-flight transfer is not aborted. It completes, including its retries.
- FSM states and transitions:
  - IDLE: go to ISSUE when the FIFO is not empty.
  - ISSUE: oReq=1, oCmd/oData = FIFO head. On iAck: pop the head into the in-flight register and go to WAIT.
  - WAIT: iDone with iNack=0 goes to IDLE. iDone with iNack=1, or the timeout counter reaching TIMEOUT_CYC, counts as a failure.
  - Failure with retry count < MAX_RETRY: increment the count and go to GAP.
  - Failure otherwise: pulse oDrop, go to IDLE.
  - GAP: wait GAP_CYC cycles, then go to REISSUE.
  - REISSUE: as ISSUE, but sends the in-flight register.
- The retry counter clears when a new frame is taken from the FIFO.
- iAck outside ISSUE/REISSUE and iDone outside WAIT are ignored.

## Timing
- Reset values: oReq=0, oCmd=0, oData=0, oDrop=0, oOverflow=0, oLevel=0, oIdle=1. FSM in IDLE, FIFO empty, no pending flags.
- Path from an event pulse in cycle 0 (FSM idle, FIFO empty):
  - Pending flag set in cycle 1.
  - FIFO entry written in cycle 2.
  - oReq=1 in cycle 3.
- oReq drops in the cycle after iAck. A new oReq needs at least IDLE→ISSUE, so back-to-back frames have ≥1 cycle with oReq=0 between them.
- The timeout counter starts the cycle after iAck. Failure is declared when it reaches TIMEOUT_CYC.
- Simultaneous FIFO push and pop: both happen and oLevel is unchanged.
- Pulses arriving during reset are lost.

## Structure
- Package game_i2c_pkg holds:
  - the command-code localparams
  - the state enum (IDLE, ISSUE, WAIT, GAP, REISSUE)
  - the packed frame struct {cmd[7:0], data[7:0]}
- Sub-module i2c_evt_fifo: synchronous FIFO of frame structs with push/pop/flush/full/empty/level. The scheduler top holds the pending stage and the FSM.

## Test plan
- iUp_P1 pulse at cycle 0 → oReq=1 at cycle 3 with oCmd=0x01, oData=0x00. After iAck then iDone (iNack=0): oIdle=1.
- iShow with iWin=2, iUp_P2 and iFinal with iResult=1 in the same cycle → frames in order 0x20/0x01, 0x10/0x02, 0x03/0x00.
- MAX_RETRY=2 and every iDone with iNack=1 → exactly 3 requests, gaps of GAP_CYC between them, one oDrop pulse, then the next frame is issued.
- No iDone after iAck → timeout at TIMEOUT_CYC, retry issued. Success on the retry → no oDrop.
- Fill the FIFO to FIFO_DEPTH while the master is stalled, then pulse iRestart → oLevel falls to 1. The in-flight frame finishes, then 0x7F/0x00 is the next frame.
- Second iDown_P1 while DOWN_P1 is still pending → oOverflow=1 and only one 0x02 frame is sent. Assert iRst_n=0 mid-WAIT → all outputs return to their reset values immediately.
